buffered_uart_tx: RTL and testbench

// - Byte-oriented UART transmitter (8N1) with an input FIFO; absorbs bursts of single-cycle byte strobes
//   (e.g. USB data strobes at 48 MHz) and serialises them on uart_tx at a fixed baud rate.
// - Sits beside the USB core as a debug/trace tap; producer never stalls, overflow bytes are dropped.

---
 rtl/buffered_uart_tx_pkg.sv | 19 +
 rtl/buffered_uart_tx_sync_fifo.sv | 63 ++++++
 rtl/buffered_uart_tx.sv | 113 +++++++++++
 tb/tb_buffered_uart_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffered_uart_tx_pkg.sv
// Shared types and constants for the buffered 8N1 UART transmitter.
package buffered_uart_tx_pkg;

    localparam int DEFAULT_CLK_FREQ = 48_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buffered_uart_tx_sync_fifo.sv
// Single-clock byte FIFO with registered empty/full; overflowing pushes and empty pops are ignored.
module buffered_uart_tx_sync_fifo
    import buffered_uart_tx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       empty,
    output logic       full
);

    localparam int PTR_W = width_for(DEPTH);
    localparam int CNT_W = width_for(DEPTH + 1);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_n = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by plain overflow.
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == CNT_W'(DEPTH));
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/buffered_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; back-to-back frames leave no idle gap.
module buffered_uart_tx
    import buffered_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD,
    parameter int DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       full,
    output logic       uart_tx
);

    localparam int                CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int                BAUD_W       = width_for(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state;
    tx_state_e         state_n;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_n;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_n;
    logic [7:0]        shift;
    logic [7:0]        shift_n;
    logic              tx_n;
    logic              pop;
    logic              fifo_empty;
    logic [7:0]        head;
    logic              baud_last;

    buffered_uart_tx_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (data_valid),
        .push_data (data),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (full)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);

    // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        tx_n    = 1'b1;
        baud_n  = (state == IDLE || baud_last) ? '0 : baud_cnt + BAUD_W'(1);
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_last) begin
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                tx_n = shift[0];
                if (baud_last) begin
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_last) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The line is registered from the current state, so it trails the FSM by one clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            uart_tx  <= tx_n;
        end
    end

endmodule

// File: tb/tb_buffered_uart_tx.sv
// Randomised and directed bench for buffered_uart_tx against a frame-schedule reference model.
module tb_buffered_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;
    localparam int DCPB  = 48_000_000 / 115_200;

    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic       full;
    logic       uart_tx;
    logic [7:0] data_def = 8'h00;
    logic       valid_def = 1'b0;
    logic       full_def;
    logic       uart_tx_def;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffered_uart_tx #(.CLK_FREQ(48_000_000), .BAUD(12_000_000), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_valid (data_valid),
        .full       (full),
        .uart_tx    (uart_tx)
    );

    buffered_uart_tx dut_def (
        .clk        (clk),
        .rst        (rst),
        .data       (data_def),
        .data_valid (valid_def),
        .full       (full_def),
        .uart_tx    (uart_tx_def)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Line level j bit-periods into a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j >= 9) return 1'b1;
        return b[j-1];
    endfunction

    // Reference model: a queue of waiting bytes plus the schedule of the frame on the wire.
    logic [7:0] q [$];
    logic [7:0] log_q [$];
    logic [7:0] rx_q [$];
    int         t = 0;
    int         busy = 0;
    int         fp = 0;
    int         pre = 0;
    bit         has_frame = 0;
    logic [7:0] fb = 8'h00;
    logic       exp_tx = 1'b1;
    logic       exp_full = 1'b0;
    bit         model_ok = 0;
    bit         saw_full = 0;

    always @(posedge clk) begin
        t++;
        if (!rst) begin
            exp_tx    = 1'b1;
            q.delete();
            has_frame = 0;
            busy      = 0;
            model_ok  = 1;
        end else begin
            if (has_frame && t >= fp + 1 && t <= fp + FRAME)
                exp_tx = frame_bit(fb, (t - fp - 1) / CPB);
            else
                exp_tx = 1'b1;
            pre = q.size();
            if (pre > 0 && t >= busy) begin
                fb        = q.pop_front();
                fp        = t;
                has_frame = 1;
                busy      = t + FRAME;
                log_q.push_back(fb);
            end
            if (data_valid && pre < DEPTH) q.push_back(data);
        end
        exp_full = (q.size() == DEPTH);
    end

    // Per-cycle line/full comparison plus an independent mid-bit decoder of the DUT line.
    bit         rx_busy = 0;
    int         rx_cnt = 0;
    int         rx_j = 0;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge clk) begin
        if (model_ok) begin
            check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx});
            check("full", {31'd0, full}, {31'd0, exp_full});
            if (full === 1'b1) saw_full = 1;
            if (!rst) begin
                rx_busy = 0;
            end else begin
                if (!rx_busy && uart_tx === 1'b0) begin
                    rx_busy = 1;
                    rx_cnt  = 0;
                    rx_byte = 8'h00;
                end else if (rx_busy) begin
                    rx_cnt++;
                end
                if (rx_busy && (rx_cnt % CPB) == CPB / 2) begin
                    rx_j = rx_cnt / CPB;
                    if (rx_j == 0) begin
                        check("start_bit", {31'd0, uart_tx}, 32'd0);
                    end else if (rx_j <= 8) begin
                        rx_byte[rx_j-1] = uart_tx;
                    end else begin
                        check("stop_bit", {31'd0, uart_tx}, 32'd1);
                        rx_q.push_back(rx_byte);
                        rx_busy = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            data       = first + 8'(i);
            data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 4000; n++) begin
            if (q.size() == 0 && t > busy + CPB) break;
            tick();
        end
        check(tag, {31'd0, (q.size() == 0 && t > busy + CPB)}, 32'd1);
    endtask

    task automatic check_bytes(input string tag, input byte_q_t exp);
        check({tag, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp[i]});
        rx_q.delete();
        log_q.delete();
    endtask

    byte_q_t exp_q;

    initial begin
        // Reset held with strobes active: nothing may be accepted or transmitted.
        rst        = 1'b0;
        data       = 8'hE7;
        data_valid = 1'b1;
        repeat (5) tick();
        rst        = 1'b1;
        data_valid = 1'b0;
        repeat (20) tick();
        check("reset_rx_empty", rx_q.size(), 0);
        check("reset_full", {31'd0, full}, 32'd0);

        push_burst(8'hA5, 1);
        repeat (50) tick();
        exp_q = '{8'hA5};
        check_bytes("single", exp_q);

        push_burst(8'h01, 3);
        drain("burst_drain");
        exp_q = '{8'h01, 8'h02, 8'h03};
        check_bytes("burst", exp_q);

        saw_full = 0;
        push_burst(8'h00, 18);
        drain("ovf_drain");
        check("ovf_saw_full", {31'd0, saw_full}, 32'd1);
        exp_q.delete();
        for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
        check_bytes("overflow", exp_q);

        // Push exactly on a pop edge while 15 bytes wait.
        push_burst(8'h20, 16);
        for (int n = 0; n < 200; n++) begin
            if (t + 1 == busy) break;
            tick();
        end
        check("pop_align", {31'd0, (t + 1 == busy && q.size() == DEPTH - 1)}, 32'd1);
        push_burst(8'h30, 1);
        check("pushpop_full", {31'd0, full}, 32'd0);
        drain("pushpop_drain");
        exp_q.delete();
        for (int i = 0; i <= 16; i++) exp_q.push_back(8'h20 + 8'(i));
        check_bytes("pushpop", exp_q);

        // Random traffic in phases of light, medium and saturating load.
        for (int ph = 0; ph < 8; ph++) begin
            int pct;
            pct = (ph % 3 == 0) ? 5 : (ph % 3 == 1) ? 30 : 90;
            for (int c = 0; c < 60; c++) begin
                data       = 8'($urandom);
                data_valid = ($urandom_range(0, 99) < pct);
                tick();
            end
        end
        data_valid = 1'b0;
        drain("rand_drain");
        exp_q = log_q;
        check_bytes("random", exp_q);

        // Reset during data bit 3 of a frame.
        push_burst(8'h5A, 1);
        repeat (18) tick();
        rst = 1'b0;
        tick();
        check("midrst_tx", {31'd0, uart_tx}, 32'd1);
        rst = 1'b1;
        repeat (60) tick();
        check("midrst_rx_empty", rx_q.size(), 0);
        log_q.delete();
        push_burst(8'hC3, 1);
        drain("midrst_drain");
        exp_q = '{8'hC3};
        check_bytes("after_rst", exp_q);

        // One frame at the default 115200 baud.
        data_def  = 8'h3D;
        valid_def = 1'b1;
        tick();
        valid_def = 1'b0;
        check("def_lat_k", {31'd0, uart_tx_def}, 32'd1);
        tick();
        check("def_lat_k1", {31'd0, uart_tx_def}, 32'd1);
        tick();
        for (int idx = 0; idx < 10 * DCPB + 8; idx++) begin
            check("def_frame", {31'd0, uart_tx_def}, {31'd0, frame_bit(8'h3D, idx / DCPB)});
            tick();
        end
        check("def_full", {31'd0, full_def}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
